spike_detect_ctrl: RTL
======================

# spike_detect_ctrl

Controller that sits downstream of the four non-linear operators (TKEO, ED, ASO, ADO) and turns their continuous outputs into spike events. It selects one operator, calibrates an adaptive threshold from that operator's mean output over a fixed window, then detects threshold crossings. After each detection it enforces a refractory period. It is the sequencing and configuration point between the operator datapath and the event output.

## Interface
- `OUT_BITS`, 29: width of the TKEO/ED inputs and of the internal compare path.
- `CAL_LOG2`, 8: calibration window is 2^CAL_LOG2 valid samples.
- `REFRACT`, 16: refractory length in valid samples (≥1).

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_valid`  in  1  strobe, one per new operator output sample; all counting/compare is gated by it.
- `start`  in  1  pulse; latches config and begins calibration.
- `stop`  in  1  pulse; returns to IDLE.
- `op_sel`  in  2  0=TKEO, 1=ED, 2=ASO, 3=ADO; latched on `start`.
- `thr_mult`  in  4  threshold multiplier on the calibrated mean; latched on `start`.
- `tkeo_in`  in  OUT_BITS  TKEO output.
- `ed_in`  in  OUT_BITS  ED output.
- `aso_in`  in  16  ASO output.
- `ado_in`  in  16  ADO output.
- `spike`  out  1  one-cycle pulse per detection.
- `threshold`  out  OUT_BITS  active threshold.
- `state`  out  2  0=IDLE, 1=CALIB, 2=DETECT, 3=REFRACT.
- `spike_count`  out  16  detections since last `start`, wrapping.

## Operation
- Selected sample `x`: the operator chosen by latched `op_sel`; ASO/ADO are zero-extended to OUT_BITS.
- IDLE: no counting. `start` → CALIB, clear accumulator, window counter, `spike_count`; latch `op_sel`/`thr_mult`.
- CALIB: on each `sample_valid`, acc += x (acc is OUT_BITS+CAL_LOG2 bits, so no overflow). On the 2^CAL_LOG2-th valid sample: mean = acc >> CAL_LOG2; threshold = mean × thr_mult, saturated to 2^OUT_BITS−1; if the result is 0 it is forced to 1; thr_mult=0 gives threshold = 2^OUT_BITS−1. Then → DETECT.
- DETECT: on `sample_valid` with x > threshold (strict), pulse `spike`, increment `spike_count`, → REFRACT. If x = threshold, there is no detection.
- REFRACT: count REFRACT valid samples; no detection; then → DETECT. A sample above threshold on the exit cycle is not detected; the first compare happens on the next valid sample.
- `stop` in any state → IDLE; `threshold` and `spike_count` hold.
- `start` in a non-IDLE state restarts calibration (same as from IDLE). `start` and `stop` in the same cycle: `stop` wins.
- `op_sel`/`thr_mult` changes outside a `start` cycle are ignored.

## Timing
- Reset values: `spike`=0, `threshold`=2^OUT_BITS−1, `state`=IDLE, `spike_count`=0; accumulator and counters are 0.
- All outputs are registered. `spike` asserts the cycle after the qualifying `sample_valid` edge (latency 1) and lasts exactly one cycle.
- `threshold` updates one cycle after the last calibration sample. `state` reads DETECT in that same cycle.
- `start`/`stop` take effect on the edge where they are sampled. A `sample_valid` in that cycle is not accumulated or compared.
- `rst_n` assertion mid-operation immediately forces all reset values (asynchronous). Deassertion is synchronised externally.
- Back-to-back `sample_valid` on every cycle is supported. There are no stall conditions.

## Structure
- Shared package `operators_pkg`: state enum (IDLE/CALIB/DETECT/REFRACT) and op_sel encodings (OP_TKEO..OP_ADO). `operators_top` uses the same encodings.
- One natural sub-module: `thr_calc` (accumulate, shift, multiply, saturate, zero-floor), which is testable alone. The FSM, refractory counter and compare live in `spike_detect_ctrl`.

## Test plan
- CAL_LOG2=2, op_sel=0, thr_mult=3, four TKEO samples of 100 → threshold=300 one cycle after the 4th; x=301 → `spike` pulse, `spike_count`=1; x=300 → no spike.
- REFRACT=4, continuous x=1000 in DETECT → spikes exactly every 5th valid sample; `state` cycles 2→3→2.
- op_sel=3 with ado_in=16'hFFFF during calibration, thr_mult=15 → threshold=15×65535 without truncation. Also exercise the saturation case with tkeo_in at max → threshold=2^29−1.
- All-zero calibration → threshold=1; thr_mult=0 → threshold=2^OUT_BITS−1 and no spikes.
- `start`+`stop` in the same cycle from DETECT → IDLE. `start` mid-CALIB → accumulator restarts and the window count resets.
- `rst_n` low during REFRACT → all outputs at reset values the same cycle; after release, `state`=IDLE until `start`.

Source files
------------

// File: rtl/operators_pkg.sv
// operators_pkg: shared state and operator-select encodings for the spike-detect path
package operators_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALIB   = 2'd1,
        ST_DETECT  = 2'd2,
        ST_REFRACT = 2'd3
    } state_t;
    typedef enum logic [1:0] {
        OP_TKEO = 2'd0,
        OP_ED   = 2'd1,
        OP_ASO  = 2'd2,
        OP_ADO  = 2'd3
    } op_sel_t;
endpackage

// File: rtl/thr_calc.sv
// thr_calc: window accumulator producing a saturated, zero-floored mean*mult threshold
module thr_calc #(
    parameter int OUT_BITS = 29,
    parameter int CAL_LOG2 = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [OUT_BITS-1:0] x,
    input  logic [3:0]          mult,
    output logic                done,
    output logic [OUT_BITS-1:0] threshold
);
    localparam logic [OUT_BITS-1:0] MAX = '1;
    localparam logic [OUT_BITS-1:0] ONE = {{(OUT_BITS-1){1'b0}}, 1'b1};
    logic [OUT_BITS+CAL_LOG2-1:0] acc, acc_nxt;
    logic [CAL_LOG2-1:0]          cnt;
    logic [OUT_BITS-1:0]          mean, thr_nxt;
    logic [OUT_BITS+3:0]          prod;
    // the last sample is folded in before the shift so the mean covers the full window
    always_comb begin
        acc_nxt = acc + {{CAL_LOG2{1'b0}}, x};
        mean    = acc_nxt[OUT_BITS+CAL_LOG2-1:CAL_LOG2];
        prod    = {4'b0, mean} * {{OUT_BITS{1'b0}}, mult};
        thr_nxt = (mult == 4'd0 || |prod[OUT_BITS+3:OUT_BITS]) ? MAX :
                  (prod[OUT_BITS-1:0] == '0) ? ONE : prod[OUT_BITS-1:0];
        done    = en && &cnt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            threshold <= MAX;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (en) begin
            acc <= done ? '0 : acc_nxt;
            cnt <= cnt + 1'b1;
            if (done) threshold <= thr_nxt;
        end
    end
endmodule

// File: rtl/spike_detect_ctrl.sv
// spike_detect_ctrl: operator select, threshold calibration, crossing detect and refractory sequencing
module spike_detect_ctrl
    import operators_pkg::*;
#(
    parameter int OUT_BITS = 29,
    parameter int CAL_LOG2 = 8,
    parameter int REFRACT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          op_sel,
    input  logic [3:0]          thr_mult,
    input  logic [OUT_BITS-1:0] tkeo_in,
    input  logic [OUT_BITS-1:0] ed_in,
    input  logic [15:0]         aso_in,
    input  logic [15:0]         ado_in,
    output logic                spike,
    output logic [OUT_BITS-1:0] threshold,
    output logic [1:0]          state,
    output logic [15:0]         spike_count
);
    localparam int RW = $clog2(REFRACT + 1);
    localparam logic [RW-1:0] RLAST = RW'(REFRACT - 1);
    state_t              st, st_nxt;
    op_sel_t             op_q;
    logic [3:0]          mult_q;
    logic [OUT_BITS-1:0] x;
    logic [RW-1:0]       rcnt;
    logic                go, quiet, cal_en, cal_done, hit, rdone;
    // start/stop own their cycle: a coincident sample is neither accumulated nor compared
    always_comb begin
        go     = start && !stop;
        quiet  = sample_valid && !start && !stop;
        x      = op_q == OP_TKEO ? tkeo_in : op_q == OP_ED ? ed_in :
                 {{(OUT_BITS-16){1'b0}}, op_q == OP_ASO ? aso_in : ado_in};
        cal_en = quiet && st == ST_CALIB;
        hit    = quiet && st == ST_DETECT && x > threshold;
        rdone  = quiet && st == ST_REFRACT && rcnt == RLAST;
        st_nxt = stop ? ST_IDLE : start ? ST_CALIB : cal_done ? ST_DETECT :
                 hit ? ST_REFRACT : rdone ? ST_DETECT : st;
        state  = st;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= ST_IDLE;
        else        st <= st_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_TKEO;
            mult_q      <= '0;
            rcnt        <= '0;
            spike       <= 1'b0;
            spike_count <= '0;
        end else begin
            spike <= hit;
            rcnt  <= hit ? '0 : (quiet && st == ST_REFRACT) ? rcnt + 1'b1 : rcnt;
            if (go) begin
                op_q        <= op_sel_t'(op_sel);
                mult_q      <= thr_mult;
                spike_count <= '0;
            end else if (hit) begin
                spike_count <= spike_count + 16'd1;
            end
        end
    end
    thr_calc #(.OUT_BITS(OUT_BITS), .CAL_LOG2(CAL_LOG2)) u_thr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (go),
        .en        (cal_en),
        .x         (x),
        .mult      (mult_q),
        .done      (cal_done),
        .threshold (threshold)
    );
endmodule
